// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decode-side handshake plus the instruction-memory address/data pair.
// The fetch unit connects through the master modport.
interface fetch_unit_if #(
  parameter int AW = 6
) ();
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_instr;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc_plus4;
  logic          fetch_fault;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_instr,
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_instr,
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, 1-cycle imem pairing, stall hold and redirect.
// Optional macro MISALIGN_TRAP_EN: misaligned redirects enter a sticky FAULT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 6
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_e      st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        f_valid_q, f_valid_d;

  logic [31:0] redir_pc;
  logic        misalign;

  assign redir_pc = {bus.redirect_target[31:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign misalign = (bus.redirect_target[1:0] != 2'b00);
`else
  // Low target bits are dropped: every redirect is treated as word aligned.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^bus.redirect_target[1:0];
  assign misalign        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q      <= RUN;
      pc_q      <= RESET_PC_ALIGNED;
      f_pc_q    <= RESET_PC_ALIGNED;
      f_valid_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      RUN:     if (bus.redirect_valid && misalign) st_d = FAULT;
      FAULT:   st_d = FAULT;
      default: st_d = RUN;
    endcase
  end

  // Priority redirect > stall > advance; FAULT freezes the PCs and kills valid.
  always_comb begin
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    if (st_q == RUN) begin
      if (bus.redirect_valid) begin
        if (misalign) begin
          f_valid_d = 1'b0;
        end else begin
          f_pc_d    = redir_pc;
          f_valid_d = 1'b1;
          pc_d      = redir_pc + 32'd4;
        end
      end else if (!bus.stall) begin
        f_pc_d    = pc_q;
        f_valid_d = 1'b1;
        pc_d      = pc_q + 32'd4;
      end
    end else begin
      f_valid_d = 1'b0;
    end
  end

  // During a stall the memory re-reads the held word so if_instr stays stable.
  always_comb begin
    if (bus.redirect_valid)  bus.imem_addr = redir_pc[AW+1:2];
    else if (bus.stall)      bus.imem_addr = f_pc_q[AW+1:2];
    else                     bus.imem_addr = pc_q[AW+1:2];
    bus.if_valid    = f_valid_q;
    bus.if_pc       = f_pc_q;
    bus.if_pc_plus4 = f_pc_q + 32'd4;
    bus.if_instr    = bus.imem_instr;
`ifdef MISALIGN_TRAP_EN
    bus.fetch_fault = (st_q == FAULT);
`else
    bus.fetch_fault = 1'b0;
`endif
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, hand sequences, wrap-around instance
// and a randomized run against an instruction-stream reference model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.AW(6)) bus ();
  fetch_unit_if #(.AW(6)) wbus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .AW(6)) u_dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .AW(6)) u_wrap (
    .clock (clk),
    .reset (reset),
    .bus   (wbus)
  );

  // Memory model: registered read, mem[i] = A000_0000 + i.
  logic [31:0] imem_q, wimem_q;
  always @(posedge clk) begin
    imem_q  <= 32'hA000_0000 + 32'(bus.imem_addr);
    wimem_q <= 32'hA000_0000 + 32'(wbus.imem_addr);
  end
  assign bus.imem_instr  = imem_q;
  assign wbus.imem_instr = wimem_q;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [5:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [5:0] a, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic f);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t; x.e_addr = a;
    x.e_valid = v; x.e_pc = pc; x.e_instr = ins; x.e_fault = f;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " rst valid"}, 32'(bus.if_valid), 32'd0);
    chk({tag, " rst pc"}, bus.if_pc, 32'h0);
    chk({tag, " rst pc4"}, bus.if_pc_plus4, 32'h4);
    chk({tag, " rst fault"}, 32'(bus.fetch_fault), 32'd0);
  endtask

  // One cycle: drive at negedge, check imem_addr, then check if_* just after the edge.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    bus.stall = v.stall;
    bus.redirect_valid = v.redir;
    bus.redirect_target = v.tgt;
    #1;
    chk({tag, " addr"}, 32'(bus.imem_addr), 32'(v.e_addr));
    @(posedge clk);
    #1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    chk({tag, " valid"}, 32'(bus.if_valid), 32'(v.e_valid));
    chk({tag, " pc"}, bus.if_pc, v.e_pc);
    chk({tag, " pc4"}, bus.if_pc_plus4, v.e_pc + 32'd4);
    chk({tag, " instr"}, bus.if_instr, v.e_instr);
    chk({tag, " fault"}, 32'(bus.fetch_fault), 32'(v.e_fault));
    $display("%s s=%b r=%b tgt=%h addr=%0d valid=%b pc=%h instr=%h fault=%b", tag,
             v.stall, v.redir, v.tgt, bus.imem_addr, bus.if_valid, bus.if_pc,
             bus.if_instr, bus.fetch_fault);
  endtask

  // Reference model: the stream is "shown PC" plus "next PC to fetch".
  logic [31:0] m_show, m_next;
  logic        m_valid, m_fault;

  initial begin
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    wbus.stall = 1'b0; wbus.redirect_valid = 1'b0; wbus.redirect_target = 32'h0;

    vecs[0]  = mk(0, 0, 32'h0,   6'd0,  1, 32'h00,  32'hA000_0000, 0);
    vecs[1]  = mk(0, 0, 32'h0,   6'd1,  1, 32'h04,  32'hA000_0001, 0);
    vecs[2]  = mk(0, 0, 32'h0,   6'd2,  1, 32'h08,  32'hA000_0002, 0);
    vecs[3]  = mk(1, 0, 32'h0,   6'd2,  1, 32'h08,  32'hA000_0002, 0);
    vecs[4]  = mk(1, 0, 32'h0,   6'd2,  1, 32'h08,  32'hA000_0002, 0);
    vecs[5]  = mk(1, 0, 32'h0,   6'd2,  1, 32'h08,  32'hA000_0002, 0);
    vecs[6]  = mk(0, 0, 32'h0,   6'd3,  1, 32'h0C,  32'hA000_0003, 0);
    vecs[7]  = mk(0, 0, 32'h0,   6'd4,  1, 32'h10,  32'hA000_0004, 0);
    vecs[8]  = mk(0, 1, 32'h20,  6'd8,  1, 32'h20,  32'hA000_0008, 0);
    vecs[9]  = mk(1, 1, 32'h40,  6'd16, 1, 32'h40,  32'hA000_0010, 0);
    vecs[10] = mk(0, 0, 32'h0,   6'd17, 1, 32'h44,  32'hA000_0011, 0);
    vecs[11] = mk(0, 1, 32'h100, 6'd0,  1, 32'h100, 32'hA000_0000, 0);
    vecs[12] = mk(0, 0, 32'h0,   6'd1,  1, 32'h104, 32'hA000_0001, 0);
`ifdef MISALIGN_TRAP_EN
    vecs[13] = mk(0, 1, 32'h22,  6'd8,  0, 32'h104, 32'hA000_0008, 1);
    vecs[14] = mk(0, 1, 32'h40,  6'd16, 0, 32'h104, 32'hA000_0010, 1);
`else
    vecs[13] = mk(0, 1, 32'h22,  6'd8,  1, 32'h20,  32'hA000_0008, 0);
    vecs[14] = mk(0, 1, 32'h40,  6'd16, 1, 32'h40,  32'hA000_0010, 0);
`endif

    // Table run: free-run, stall, redirect, redirect+stall, aliasing, misaligned target.
    do_reset(2);
    check_reset_state("tbl");
    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Reset clears fault and valid; then redirect while if_pc=4 squashes the word at 8.
    do_reset(1);
    check_reset_state("redir");
    step("redir0", mk(0, 0, 32'h0,  6'd0, 1, 32'h00, 32'hA000_0000, 0));
    step("redir1", mk(0, 0, 32'h0,  6'd1, 1, 32'h04, 32'hA000_0001, 0));
    step("redir2", mk(0, 1, 32'h20, 6'd8, 1, 32'h20, 32'hA000_0008, 0));
    step("redir3", mk(0, 0, 32'h0,  6'd9, 1, 32'h24, 32'hA000_0009, 0));

    // Reset while stall and redirect are both asserted discards them.
    @(negedge clk);
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h80;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    check_reset_state("midrst");
    step("midrst0", mk(0, 0, 32'h0, 6'd0, 1, 32'h00, 32'hA000_0000, 0));

    // Wrap-around instance: RESET_PC = FFFF_FFF8.
    do_reset(2);
    chk("wrap rst valid", 32'(wbus.if_valid), 32'd0);
    chk("wrap rst pc", wbus.if_pc, 32'hFFFF_FFF8);
    chk("wrap rst pc4", wbus.if_pc_plus4, 32'hFFFF_FFFC);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] epc;
      epc = 32'hFFFF_FFF8 + 32'(k * 4);
      @(negedge clk);
      chk($sformatf("wrap%0d addr", k), 32'(wbus.imem_addr), 32'(epc[7:2]));
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d pc", k), wbus.if_pc, epc);
      chk($sformatf("wrap%0d pc4", k), wbus.if_pc_plus4, epc + 32'd4);
      chk($sformatf("wrap%0d instr", k), wbus.if_instr, 32'hA000_0000 + 32'(epc[7:2]));
      chk($sformatf("wrap%0d valid", k), 32'(wbus.if_valid), 32'd1);
      $display("wrap%0d pc=%h instr=%h", k, wbus.if_pc, wbus.if_instr);
    end

    // Randomized run against the stream model.
    do_reset(1);
    check_reset_state("rnd");
    m_show = 32'h0; m_next = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    for (int n = 0; n < 300; n++) begin
      vec_t v;
      logic s, r;
      logic [31:0] t;
      logic [31:0] fetch_pc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 6) == 0);
      t = $urandom;
`ifdef MISALIGN_TRAP_EN
      t[1:0] = 2'b00;
`endif
      // Which byte address the memory is asked for this cycle.
      if (r)      fetch_pc = t;
      else if (s) fetch_pc = m_show;
      else        fetch_pc = m_next;
      if (!m_fault) begin
        if (r) begin
`ifdef MISALIGN_TRAP_EN
          if (t[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
          end else
`endif
          begin
            m_show = t & 32'hFFFF_FFFC;
            m_next = m_show + 32'd4;
            m_valid = 1'b1;
          end
        end else if (!s) begin
          m_show = m_next;
          m_next = m_next + 32'd4;
          m_valid = 1'b1;
        end
      end
      v = mk(s, r, t, fetch_pc[7:2], m_valid, m_show,
             32'hA000_0000 + 32'(fetch_pc[7:2]), m_fault);
      step($sformatf("rnd%0d", n), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
